bcd_updown_counter: RTL
=======================

# bcd_updown_counter

Parametrised multi-digit up/down counter for the stopwatch datapath: a chain of DIGITS digit counters, each with modulus RADIX. Each digit wraps up (RADIX-1 → 0) and down (0 → RADIX-1), propagating carry and borrow to the next digit. Parallel load, synchronous clear, chain wrap pulse and zero detect let one instance serve as the stopwatch or countdown-timer core feeding the display decoders.

## Interface
- DIGITS, 4, number of digits; legal 1..8
- RADIX, 10, modulus of every digit; legal 2..10; each digit is 4 bits
- clk  in  1  clock, rising-edge active
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  count tick; one step per cycle while high
- up  in  1  1 = count up, 0 = count down; sampled with en
- clear  in  1  synchronous clear to all zeros
- load  in  1  synchronous parallel load
- load_val  in  4*DIGITS  load value; digit i in bits [4i+3:4i], digit 0 least significant
- count  out  4*DIGITS  current value, same packing as load_val
- wrap  out  1  one-cycle pulse after the whole chain wraps
- zero  out  1  high when every digit of count is 0

## Operation
- Priority per edge: clear > load > en. If none is high, hold.
- clear: count ← 0, wrap ← 0.
- load: each digit ← load_val digit, clamped to RADIX-1 when the digit is ≥ RADIX. Example: RADIX=10, digit 4'hC loads as 9. wrap ← 0.
- en, up=1: digit 0 increments. Digit i increments only when digits 0..i-1 are all RADIX-1. A digit at RADIX-1 that increments goes to 0.
- en, up=0: digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0. A digit at 0 that decrements goes to RADIX-1.
- Chain wrap:
  - Up from all RADIX-1 → all 0.
  - Down from all 0 → all RADIX-1.
  - Either case sets wrap=1 for the next cycle only.
- Digit values never leave 0..RADIX-1 under any input sequence after reset.
- up is ignored while en=0. Changing up between ticks takes effect on the next tick with no extra delay.
- zero is combinational from count. All other outputs are registered.

## Timing
- Reset (rst_n=0, asynchronous): count=0, wrap=0, so zero=1. Reset mid-count discards state immediately. The first tick after rst_n rises acts on a count of 0.
- Latency: count reflects en/load/clear at the rising edge where they are sampled high, so it is visible 1 cycle later.
- wrap is high for exactly the one cycle after the wrapping edge. With en held high continuously, consecutive wraps are separated by RADIX^DIGITS cycles.
- Simultaneous events:
  - clear with load or en: clear wins.
  - load with en: load wins and no step is taken on that edge.
- Carry/borrow ripple is fully combinational within one cycle. There is no multi-cycle carry.

## Configuration
- STOPWATCH_SATURATE_EN defined:
  - A tick that would cause a chain wrap is suppressed, so count holds.
  - Up holds at all RADIX-1; down holds at all 0 (countdown stops at zero).
  - wrap never asserts.
  - Non-wrapping ticks, load and clear behave as normal.
- Not defined: wrap-around behaviour as described in Operation, with wrap asserted on each chain wrap.

## Test plan
- Reset mid-count: DIGITS=4, RADIX=10. Count to 0123, pull rst_n low between edges → count=0000, zero=1, wrap=0 without waiting for a clock edge.
- Up carry chain: load 0999, 1 tick up → 1000, wrap=0. Load 9999, 1 tick up → 0000, wrap=1 for exactly one cycle, zero=1.
- Down borrow chain: load 1000, 1 tick down → 0999. Load 0000, 1 tick down → 9999, wrap=1 for one cycle.
  - With STOPWATCH_SATURATE_EN: load 0000, tick down → count stays 0000, wrap stays 0. Load 9999, tick up → count stays 9999.
- Load clamp and priority:
  - load_val=16'h0A5F → count=0959.
  - load with en=1, up=1 on the same edge → count=load value with no step taken.
  - clear, load and en together → 0000.
- Radix generality: DIGITS=2, RADIX=6. Start at 00, en high for 36 ticks up → sequence 00…05,10…55,00; wrap pulses once, on the 36th tick.
- Direction flip: count at 0010, ticks up, down, down → 0011, 0010, 0009. en=0 while toggling up → count holds.

Source files
------------

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_updown_counter
//  Purpose  : Chain of DIGITS up/down digit counters, each modulo RADIX, with
//             parallel load (clamped per digit), synchronous clear, a chain
//             wrap pulse and a zero flag. Core of the stopwatch / countdown
//             timer datapath.
//  Option   : STOPWATCH_SATURATE_EN - when defined, a tick that would wrap the
//             whole chain is suppressed (count holds, wrap never asserts).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
   parameter int DIGITS = 4,
   parameter int RADIX  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic                  zero
);

   localparam logic [3:0] C_MAX   = 4'(RADIX - 1);
   localparam logic [3:0] C_RADIX = 4'(RADIX);

   logic [4*DIGITS-1:0] r_count;
   logic                r_wrap;

   logic [3:0]          w_digit [DIGITS];
   logic [DIGITS:0]     w_max_chain;   // bit i: digits 0..i-1 all at RADIX-1
   logic [DIGITS:0]     w_zero_chain;  // bit i: digits 0..i-1 all at 0
   logic [4*DIGITS-1:0] w_count_step;
   logic [4*DIGITS-1:0] w_count_load;
   logic                w_chain_wrap;
   logic                w_step;
   logic                w_wrap_next;

   // Per-digit step and load values; a digit moves only when every lower
   // digit is at its carry (up) or borrow (down) boundary.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_up_val;
      logic [3:0] w_dn_val;
      logic [3:0] w_ld_raw;

      assign w_digit[gi] = r_count[4*gi +: 4];
      assign w_up_val    = (w_digit[gi] == C_MAX) ? 4'd0  : w_digit[gi] + 4'd1;
      assign w_dn_val    = (w_digit[gi] == 4'd0)  ? C_MAX : w_digit[gi] - 4'd1;
      assign w_ld_raw    = load_val[4*gi +: 4];

      assign w_count_step[4*gi +: 4] =
         up ? (w_max_chain[gi]  ? w_up_val : w_digit[gi])
            : (w_zero_chain[gi] ? w_dn_val : w_digit[gi]);

      // Out-of-range load digits are clamped so a digit never leaves 0..RADIX-1.
      assign w_count_load[4*gi +: 4] = (w_ld_raw >= C_RADIX) ? C_MAX : w_ld_raw;
   end

   // Ripple the carry/borrow enables through the chain in one cycle.
   always_comb begin
      w_max_chain[0]  = 1'b1;
      w_zero_chain[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         w_max_chain[i+1]  = w_max_chain[i]  & (w_digit[i] == C_MAX);
         w_zero_chain[i+1] = w_zero_chain[i] & (w_digit[i] == 4'd0);
      end
   end

   assign w_chain_wrap = en & (up ? w_max_chain[DIGITS] : w_zero_chain[DIGITS]);

`ifdef STOPWATCH_SATURATE_EN
   // A wrapping tick is dropped: count holds at the end stop, no pulse.
   assign w_step      = en & ~w_chain_wrap;
   assign w_wrap_next = 1'b0;
`else
   assign w_step      = en;
   assign w_wrap_next = w_chain_wrap;
`endif

   // Count register: clear beats load beats tick; wrap is a one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_count <= w_count_load;
         r_wrap  <= 1'b0;
      end else if (w_step) begin
         r_count <= w_count_step;
         r_wrap  <= w_wrap_next;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;
   assign zero  = (r_count == '0);

endmodule
`default_nettype wire
